block_ram_bridge: RTL and testbench



---
 rtl/block_ram_bridge.sv | 118 +++++++++++
 tb/tb_block_ram_bridge.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/block_ram_bridge.sv
// Valid/ready request/response front end for a single-port BlockRam.
// Hides the one-cycle read latency and does byte-strobed writes as read-modify-write.
module block_ram_bridge #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [DATA_WIDTH-1:0]   ram_din,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic                    ram_we,
  input  logic [DATA_WIDTH-1:0]   ram_dout
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {StIdle, StRd, StMerge} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   strb_q;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [DATA_WIDTH-1:0]   merged;
  logic                    accept;
  logic                    strb_full, strb_null;

  assign req_ready = (state_q == StIdle) && !rst && (!rsp_valid_q || rsp_ready);
  assign accept    = req_valid && req_ready;
  assign strb_full = &req_strb;
  assign strb_null = ~|req_strb;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

  always_comb begin
    merged = '0;
    for (int i = 0; i < int'(STRB_WIDTH); i++) begin
      merged[8*i +: 8] = strb_q[i] ? wdata_q[8*i +: 8] : ram_dout[8*i +: 8];
    end
  end

  // RD and MERGE are only entered with the response slot empty, so they load it unconditionally.
  always_comb begin
    state_d     = state_q;
    ram_addr    = addr_q;
    ram_din     = wdata_q;
    ram_we      = 1'b0;
    rsp_valid_d = rsp_valid_q && !rsp_ready;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      StIdle: begin
        ram_addr = req_addr;
        ram_din  = req_wdata;
        if (accept) begin
          if (!req_we) begin
            state_d = StRd;
          end else if (strb_full) begin
            ram_we      = 1'b1;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
          end else if (strb_null) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d = StMerge;
          end
        end
      end
      StRd: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = ram_dout;
        state_d     = StIdle;
      end
      StMerge: begin
        ram_din     = merged;
        ram_we      = 1'b1;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = '0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (rst) begin
      ram_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        strb_q  <= req_strb;
      end
    end
  end

endmodule

// File: tb/tb_block_ram_bridge.sv
// Directed bench for block_ram_bridge with a behavioural single-port RAM attached.
module tb_block_ram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [31:0] ram_din, ram_dout;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [31:0] mem [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Read-first single-port RAM, dout registered one cycle after the address.
  always @(posedge clk) begin
    if (ram_we === 1'b1) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  block_ram_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_strb  (req_strb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .ram_din   (ram_din),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_dout  (ram_dout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic we, input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] s);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_strb  = s;
  endtask

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b1;
    set_req(1'b1, 8'h10, 32'h1111_1111, 4'hF);

    // Reset held two cycles with a write pending
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #2;
      check("rst_req_ready", {31'd0, req_ready}, 32'd0);
      check("rst_ram_we", {31'd0, ram_we}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    end
    cyc();
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    rst = 1'b0;
    req_valid = 1'b0;

    // Full write 0xDEADBEEF to 0x10
    cyc();
    set_req(1'b1, 8'h10, 32'hDEAD_BEEF, 4'hF);
    #1;
    check("fw_req_ready", {31'd0, req_ready}, 32'd1);
    check("fw_ram_we", {31'd0, ram_we}, 32'd1);
    check("fw_ram_addr", {24'd0, ram_addr}, 32'h10);
    check("fw_ram_din", ram_din, 32'hDEAD_BEEF);
    cyc();
    req_valid = 1'b0;
    #1;
    check("fw_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("fw_rsp_rdata", rsp_rdata, 32'd0);
    check("fw_ram_we_after", {31'd0, ram_we}, 32'd0);

    // Read 0x10: response at M+2
    cyc();
    set_req(1'b0, 8'h10, 32'h0, 4'h0);
    #1;
    check("rd_req_ready", {31'd0, req_ready}, 32'd1);
    check("rd_ram_we", {31'd0, ram_we}, 32'd0);
    cyc();
    req_valid = 1'b0;
    #1;
    check("rd_m1_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rd_m1_req_ready", {31'd0, req_ready}, 32'd0);
    cyc();
    check("rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);

    // Partial write strb 0x1, issued while the read response drains
    set_req(1'b1, 8'h10, 32'h0000_00AA, 4'h1);
    #1;
    check("pw1_req_ready", {31'd0, req_ready}, 32'd1);
    check("pw1_ram_we_acc", {31'd0, ram_we}, 32'd0);
    cyc();
    req_valid = 1'b0;
    #1;
    check("pw1_merge_we", {31'd0, ram_we}, 32'd1);
    check("pw1_merge_addr", {24'd0, ram_addr}, 32'h10);
    check("pw1_merge_din", ram_din, 32'hDEAD_BEAA);
    check("pw1_merge_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    cyc();
    check("pw1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("pw1_rsp_rdata", rsp_rdata, 32'd0);

    // Partial write strb 0x6
    set_req(1'b1, 8'h10, 32'h1234_5600, 4'h6);
    #1;
    check("pw2_ram_we_acc", {31'd0, ram_we}, 32'd0);
    cyc();
    req_valid = 1'b0;
    #1;
    check("pw2_merge_we", {31'd0, ram_we}, 32'd1);
    check("pw2_merge_din", ram_din, 32'hDE34_56AA);
    cyc();
    check("pw2_rsp_valid", {31'd0, rsp_valid}, 32'd1);

    // Read back merged word
    set_req(1'b0, 8'h10, 32'h0, 4'h0);
    cyc();
    req_valid = 1'b0;
    cyc();
    check("pw_read_valid", {31'd0, rsp_valid}, 32'd1);
    check("pw_read_rdata", rsp_rdata, 32'hDE34_56AA);

    // Backpressure: read, then hold rsp_ready low with a full write queued
    set_req(1'b0, 8'h10, 32'h0, 4'h0);
    cyc();
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    cyc();
    set_req(1'b1, 8'h20, 32'hCAFE_F00D, 4'hF);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_rsp_rdata", rsp_rdata, 32'hDE34_56AA);
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
      check("bp_ram_we", {31'd0, ram_we}, 32'd0);
      cyc();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_rel_req_ready", {31'd0, req_ready}, 32'd1);
    check("bp_rel_ram_we", {31'd0, ram_we}, 32'd1);
    check("bp_rel_ram_addr", {24'd0, ram_addr}, 32'h20);
    cyc();
    req_valid = 1'b0;
    #1;
    check("bp_new_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("bp_new_rsp_rdata", rsp_rdata, 32'd0);

    // Null write: no RAM write, response next cycle
    cyc();
    set_req(1'b1, 8'h10, 32'hFFFF_FFFF, 4'h0);
    #1;
    check("nw_req_ready", {31'd0, req_ready}, 32'd1);
    check("nw_ram_we", {31'd0, ram_we}, 32'd0);
    cyc();
    req_valid = 1'b0;
    #1;
    check("nw_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("nw_rsp_rdata", rsp_rdata, 32'd0);
    check("nw_ram_we_after", {31'd0, ram_we}, 32'd0);
    set_req(1'b0, 8'h10, 32'h0, 4'h0);
    cyc();
    req_valid = 1'b0;
    cyc();
    check("nw_read_rdata", rsp_rdata, 32'hDE34_56AA);
    set_req(1'b0, 8'h20, 32'h0, 4'h0);
    cyc();
    req_valid = 1'b0;
    cyc();
    check("fw20_read_rdata", rsp_rdata, 32'hCAFE_F00D);

    // Reset asserted in the MERGE cycle of a strb 0x3 write
    set_req(1'b1, 8'h10, 32'h0000_BBCC, 4'h3);
    #1;
    check("rm_req_ready", {31'd0, req_ready}, 32'd1);
    cyc();
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rm_ram_we", {31'd0, ram_we}, 32'd0);
    check("rm_req_ready_rst", {31'd0, req_ready}, 32'd0);
    cyc();
    rst = 1'b0;
    #1;
    check("rm_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rm_req_ready_after", {31'd0, req_ready}, 32'd1);
    check("rm_ram_we_after", {31'd0, ram_we}, 32'd0);
    set_req(1'b0, 8'h10, 32'h0, 4'h0);
    cyc();
    req_valid = 1'b0;
    cyc();
    check("rm_read_valid", {31'd0, rsp_valid}, 32'd1);
    check("rm_read_rdata", rsp_rdata, 32'hDE34_56AA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
